// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and constants for the IF/MEM bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbDone = 2'd2
    } arb_state_e;

    typedef enum logic {
        ArbOwnerIf  = 1'b0,
        ArbOwnerMem = 1'b1
    } arb_owner_e;

    // This block resets on rst==0, so RstEnable is the low level here.
    localparam logic        RstEnable   = 1'b0;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [3:0]  SelAllLanes = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external bus port between instruction fetch and the MEM stage.
// Optional bus-ack timeout is compiled in with `define MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        stallreq_if_o,
    input  logic        dm_ce_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_data_i,
    output logic [31:0] dm_data_o,
    output logic        stallreq_mem_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a port holds *_ce_i high until its stallreq drops; the cycle
    // with ce high and stallreq low (DONE) is the single transfer cycle. On the
    // bus side bus_ce_o is held with stable controls until a one-cycle bus_ack_i.

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q;
    logic        store_q;
    logic        discard_q;
    logic [31:0] buf_q;
    logic        grant;
    logic        timeout_hit;

    assign dbg_state_o = state_q;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == ArbBusy) && !bus_ack_i &&
                         (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign bus_err_o   = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state_q != ArbBusy) begin
                tmo_cnt_q <= '0;
            end else if (!bus_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            ArbIdle: begin
                grant = !flush_i && (dm_ce_i || if_ce_i);
                if (grant) begin
                    state_d = ArbBusy;
                end
            end
            ArbBusy: begin
                if (bus_ack_i || timeout_hit) begin
                    state_d = (discard_q || flush_i) ? ArbIdle : ArbDone;
                end
            end
            ArbDone: state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    always_comb begin
        if_data_o      = ZeroWord;
        dm_data_o      = ZeroWord;
        stallreq_if_o  = if_ce_i & ~((state_q == ArbDone) && (owner_q == ArbOwnerIf));
        stallreq_mem_o = dm_ce_i & ~((state_q == ArbDone) && (owner_q == ArbOwnerMem));
        if ((state_q == ArbDone) && !flush_i) begin
            if (owner_q == ArbOwnerIf) begin
                if_data_o = buf_q;
            end else if (store_q != WriteEnable) begin
                dm_data_o = buf_q;
            end
        end
    end

    // Bus pins, owner and capture buffer all move on state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            bus_ce_o   <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= ZeroWord;
            bus_sel_o  <= 4'b0000;
            bus_data_o <= ZeroWord;
            owner_q    <= ArbOwnerIf;
            store_q    <= 1'b0;
            discard_q  <= 1'b0;
            buf_q      <= ZeroWord;
        end else begin
            case (state_q)
                ArbIdle: begin
                    if (grant) begin
                        bus_ce_o  <= ChipEnable;
                        discard_q <= 1'b0;
                        if (dm_ce_i) begin
                            owner_q    <= ArbOwnerMem;
                            store_q    <= dm_we_i;
                            bus_we_o   <= dm_we_i;
                            bus_addr_o <= dm_addr_i;
                            bus_sel_o  <= dm_sel_i;
                            bus_data_o <= dm_data_i;
                        end else begin
                            owner_q    <= ArbOwnerIf;
                            store_q    <= 1'b0;
                            bus_we_o   <= 1'b0;
                            bus_addr_o <= if_addr_i;
                            bus_sel_o  <= SelAllLanes;
                            bus_data_o <= ZeroWord;
                        end
                    end
                end
                ArbBusy: begin
                    if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        buf_q    <= bus_data_i;
                        bus_ce_o <= 1'b0;
                        bus_we_o <= 1'b0;
                    end else if (timeout_hit) begin
                        buf_q    <= ZeroWord;
                        bus_ce_o <= 1'b0;
                        bus_we_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (timeout case runs when
// MEM_BUS_ARB_TIMEOUT_EN is defined, with TIMEOUT_CYCLES=4).
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        stallreq_if_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_data_i;
    logic [31:0] dm_data_o;
    logic        stallreq_mem_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic [1:0]  dbg_state_o;

    int unsigned n_vec;
    int unsigned n_bad;
    logic [31:0] exp_q[$];

    localparam logic [31:0] StIdle = 32'd0;
    localparam logic [31:0] StDone = 32'd2;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .stallreq_if_o  (stallreq_if_o),
        .dm_ce_i        (dm_ce_i),
        .dm_we_i        (dm_we_i),
        .dm_addr_i      (dm_addr_i),
        .dm_sel_i       (dm_sel_i),
        .dm_data_i      (dm_data_i),
        .dm_data_o      (dm_data_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_ce_o       (bus_ce_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_sel_o      (bus_sel_o),
        .bus_data_o     (bus_data_o),
        .bus_data_i     (bus_data_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_o      (bus_err_o),
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (applied %0d)", n_vec);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i    = 1'b0;
        if_ce_i    = 1'b0;
        if_addr_i  = 32'h0;
        dm_ce_i    = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = 32'h0;
        dm_sel_i   = 4'h0;
        dm_data_i  = 32'h0;
        bus_data_i = 32'h0;
        bus_ack_i  = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] word, input bit expect_read);
        bus_ack_i  = 1'b1;
        bus_data_i = word;
        if (expect_read) exp_q.push_back(word);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] w;
        w = 32'hFFFF_FFFF;
        if (exp_q.size() > 0) w = exp_q.pop_front();
        return w;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg_state_o), StIdle);
        check("rst_bus_ce", 32'(bus_ce_o), 32'd0);
        check("rst_bus_addr", bus_addr_o, 32'h0);
        check("rst_bus_sel", 32'(bus_sel_o), 32'h0);
        check("rst_if_data", if_data_o, 32'h0);
        check("rst_dm_data", dm_data_o, 32'h0);
        check("rst_bus_err", 32'(bus_err_o), 32'd0);
        rst = 1'b1;

        // zero-wait load
        tick(); dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100; dm_sel_i = 4'hF; #2;
        check("ld_c0_stall", 32'(stallreq_mem_o), 32'd1);
        check("ld_c0_bus_ce", 32'(bus_ce_o), 32'd0);
        tick(); ack_with(32'hDEADBEEF, 1'b1); #2;
        check("ld_c1_bus_ce", 32'(bus_ce_o), 32'd1);
        check("ld_c1_addr", bus_addr_o, 32'h100);
        check("ld_c1_we", 32'(bus_we_o), 32'd0);
        check("ld_c1_data", dm_data_o, 32'h0);
        tick(); bus_ack_i = 1'b0; #2;
        check("ld_c2_data", dm_data_o, pop_exp());
        check("ld_c2_stall", 32'(stallreq_mem_o), 32'd0);
        check("ld_c2_bus_ce", 32'(bus_ce_o), 32'd0);
        tick(); dm_ce_i = 1'b0; #2;
        check("ld_c3_data", dm_data_o, 32'h0);
        check("ld_c3_state", 32'(dbg_state_o), StIdle);

        // stray ack in IDLE, and flush blocking a grant
        tick(); bus_ack_i = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h40; flush_i = 1'b1; #2;
        check("flidle_state0", 32'(dbg_state_o), StIdle);
        tick(); bus_ack_i = 1'b0; flush_i = 1'b0; if_ce_i = 1'b0; #2;
        check("flidle_state1", 32'(dbg_state_o), StIdle);
        check("flidle_bus_ce", 32'(bus_ce_o), 32'd0);

        // simultaneous store + fetch: MEM first
        tick(); if_ce_i = 1'b1; if_addr_i = 32'h44;
        dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_sel_i = 4'b0010; dm_data_i = 32'h11223344; #2;
        check("sim_c0_stall_if", 32'(stallreq_if_o), 32'd1);
        check("sim_c0_stall_mem", 32'(stallreq_mem_o), 32'd1);
        tick(); ack_with(32'hAAAA5555, 1'b0); #2;
        check("sim_st_we", 32'(bus_we_o), 32'd1);
        check("sim_st_sel", 32'(bus_sel_o), 32'h2);
        check("sim_st_addr", bus_addr_o, 32'h200);
        check("sim_st_wdata", bus_data_o, 32'h11223344);
        check("sim_st_stall_if", 32'(stallreq_if_o), 32'd1);
        tick(); bus_ack_i = 1'b0; #2;
        check("sim_st_done_data", dm_data_o, 32'h0);
        check("sim_st_done_stall", 32'(stallreq_mem_o), 32'd0);
        check("sim_st_done_stall_if", 32'(stallreq_if_o), 32'd1);
        tick(); dm_ce_i = 1'b0; dm_we_i = 1'b0; #2;
        check("sim_idle_bus_ce", 32'(bus_ce_o), 32'd0);
        check("sim_idle_state", 32'(dbg_state_o), StIdle);
        check("sim_idle_stall_if", 32'(stallreq_if_o), 32'd1);
        tick(); ack_with(32'h13579BDF, 1'b1); #2;
        check("sim_if_addr", bus_addr_o, 32'h44);
        check("sim_if_we", 32'(bus_we_o), 32'd0);
        check("sim_if_sel", 32'(bus_sel_o), 32'hF);
        check("sim_if_stall", 32'(stallreq_if_o), 32'd1);
        tick(); bus_ack_i = 1'b0; #2;
        check("sim_if_data", if_data_o, pop_exp());
        check("sim_if_release", 32'(stallreq_if_o), 32'd0);
        tick(); if_ce_i = 1'b0; #2;
        check("sim_if_data_after", if_data_o, 32'h0);

        // fetch of 0x0 with three wait states
        tick(); if_ce_i = 1'b1; if_addr_i = 32'h0; #2;
        for (int i = 1; i <= 3; i++) begin
            tick(); #2;
            check("ws_bus_ce", 32'(bus_ce_o), 32'd1);
            check("ws_addr", bus_addr_o, 32'h0);
            check("ws_if_data", if_data_o, 32'h0);
        end
        tick(); ack_with(32'hCAFEF00D, 1'b1); #2;
        check("ws_c4_bus_ce", 32'(bus_ce_o), 32'd1);
        tick(); bus_ack_i = 1'b0; #2;
        check("ws_c5_data", if_data_o, pop_exp());
        check("ws_c5_stall", 32'(stallreq_if_o), 32'd0);
        tick(); if_ce_i = 1'b0;

        // flush during BUSY discards the fetch result
        tick(); if_ce_i = 1'b1; if_addr_i = 32'h80; #2;
        tick(); flush_i = 1'b1; #2;
        check("flb_c1_bus_ce", 32'(bus_ce_o), 32'd1);
        tick(); flush_i = 1'b0; ack_with(32'h55AA55AA, 1'b0); #2;
        check("flb_c2_bus_ce", 32'(bus_ce_o), 32'd1);
        check("flb_c2_addr", bus_addr_o, 32'h80);
        tick(); bus_ack_i = 1'b0; #2;
        check("flb_c3_state", 32'(dbg_state_o), StIdle);
        check("flb_c3_if_data", if_data_o, 32'h0);
        check("flb_c3_stall", 32'(stallreq_if_o), 32'd1);
        tick(); ack_with(32'h0BADCAFE, 1'b1); #2;
        check("flb_c4_bus_ce", 32'(bus_ce_o), 32'd1);
        check("flb_c4_addr", bus_addr_o, 32'h80);
        tick(); bus_ack_i = 1'b0; #2;
        check("flb_c5_data", if_data_o, pop_exp());
        tick(); if_ce_i = 1'b0;

        // flush during DONE suppresses load data
        tick(); dm_ce_i = 1'b1; dm_addr_i = 32'h104; dm_sel_i = 4'hF; #2;
        tick(); ack_with(32'h12345678, 1'b0); #2;
        tick(); bus_ack_i = 1'b0; flush_i = 1'b1; #2;
        check("fld_state", 32'(dbg_state_o), StDone);
        check("fld_data", dm_data_o, 32'h0);
        tick(); flush_i = 1'b0; dm_ce_i = 1'b0;

        // asynchronous reset in the middle of a bus cycle
        tick(); dm_ce_i = 1'b1; dm_addr_i = 32'h300; dm_sel_i = 4'hF; #2;
        tick(); #2;
        check("arst_pre_bus_ce", 32'(bus_ce_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_bus_ce", 32'(bus_ce_o), 32'd0);
        check("arst_bus_addr", bus_addr_o, 32'h0);
        check("arst_state", 32'(dbg_state_o), StIdle);
        dm_ce_i = 1'b0;
        tick(); tick(); rst = 1'b1;
        tick(); dm_ce_i = 1'b1; dm_addr_i = 32'h304; #2;
        check("arst_post_state", 32'(dbg_state_o), StIdle);
        tick(); ack_with(32'h77777777, 1'b1); #2;
        check("arst_post_addr", bus_addr_o, 32'h304);
        tick(); bus_ack_i = 1'b0; #2;
        check("arst_post_data", dm_data_o, pop_exp());
        check("arst_post_stall", 32'(stallreq_mem_o), 32'd0);
        tick(); dm_ce_i = 1'b0; #2;
        check("arst_post_err", 32'(bus_err_o), 32'd0);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // no ack: abort after four BUSY cycles
        tick(); dm_ce_i = 1'b1; dm_addr_i = 32'h400; dm_sel_i = 4'hF; #2;
        for (int i = 1; i <= 4; i++) begin
            tick(); #2;
            check("tmo_busy_ce", 32'(bus_ce_o), 32'd1);
            check("tmo_busy_err", 32'(bus_err_o), 32'd0);
        end
        tick(); #2;
        check("tmo_err", 32'(bus_err_o), 32'd1);
        check("tmo_data", dm_data_o, 32'h0);
        check("tmo_stall", 32'(stallreq_mem_o), 32'd0);
        check("tmo_bus_ce", 32'(bus_ce_o), 32'd0);
        tick(); dm_ce_i = 1'b0; #2;
        check("tmo_err_off", 32'(bus_err_o), 32'd0);
        check("tmo_state", 32'(dbg_state_o), StIdle);
`endif

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external RAM/bus port between instruction fetch (IF) and the MEM-stage load/store port.
- The MEM port carries the mem_addr/mem_we/mem_sel/mem_data/mem_ce signals.
- Sequences each access as request -> bus cycle -> ack -> one-cycle result, and raises stall requests to ctrl until the result is delivered.
- Sits between the if/mem stages and the top-level bus pins.

Parameters:
- TIMEOUT_CYCLES, 16: max bus cycles awaiting ack before abort. Used only with the optional feature.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low (asserted when rst==0)
- flush_i  in  1  pipeline flush; discard the in-flight result
- if_ce_i  in  1  IF fetch request
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction, valid only in IF DONE cycle, else 0
- stallreq_if_o  out  1  IF stall request
- dm_ce_i  in  1  MEM access request
- dm_we_i  in  1  1=store
- dm_addr_i  in  32  data address
- dm_sel_i  in  4  byte lanes, bit3=bits[31:24]
- dm_data_i  in  32  store data
- dm_data_o  out  32  load data, valid only in MEM DONE cycle for loads, else 0
- stallreq_mem_o  out  1  MEM stall request
- bus_ce_o  out  1  bus cycle active
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  bus address
- bus_sel_o  out  4  bus byte enables
- bus_data_o  out  32  bus write data
- bus_data_i  in  32  bus read data
- bus_ack_i  in  1  bus ack, one cycle per access
- bus_err_o  out  1  timeout pulse; tied 0 without the feature

Behaviour:
- Reset (rst==0, asynchronous):
  - state=IDLE, owner=IF, discard=0, data buffer=0.
  - All bus_* outputs 0, so bus_ce_o drops immediately even mid-access.
  - if/dm data outputs 0, bus_err_o 0.
- States: IDLE, BUSY, DONE. Bus outputs and data buffer are registered.
- IDLE:
  - dm_ce_i=1 has fixed priority over if_ce_i.
  - On a request: latch owner, drive bus_* from the selected port at the next edge, go to BUSY.
  - The IF grant drives bus_we_o=0 and bus_sel_o=4'b1111.
  - flush_i in IDLE blocks granting that cycle.
  - No request: stay in IDLE, bus_ce_o=0.
- BUSY:
  - Hold bus_* stable until bus_ack_i.
  - On ack: capture bus_data_i, drop bus_ce_o/bus_we_o at the edge.
  - Then go to DONE, or go to IDLE if discard=1.
  - flush_i during BUSY sets discard; the bus cycle is never aborted.
- DONE:
  - Exactly one cycle; drive the captured word on the owner's data output.
  - dm_data_o stays 0 if the access was a store.
  - Return to IDLE.
  - flush_i in DONE suppresses the output; data stays 0.
- Stall outputs (combinational):
  - stallreq_if_o = if_ce_i & ~(state==DONE & owner==IF).
  - stallreq_mem_o = dm_ce_i & ~(state==DONE & owner==MEM).
- Latency: request seen cycle 0, bus driven cycle 1, earliest ack cycle 1, data and stall release cycle 2. Each extra wait state adds 1 cycle.
- Back-to-back: at most one access is in flight. Both requests pending in IDLE -> MEM first, IF served in the following IDLE.
- Ack outside BUSY is ignored.

Optional Feature:
- MEM_BUS_ARB_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - At TIMEOUT_CYCLES the block drops bus_ce_o, pulses bus_err_o for 1 cycle, and enters DONE with data buffer=0.
  - An ack arriving in the same cycle as the limit wins: normal completion, no error.
- Undefined: BUSY waits indefinitely; bus_err_o constant 0; no counter logic.

Decomposition:
- defines.v gets:
  - state encodings ArbIdle/ArbBusy/ArbDone (2 bits)
  - owner codes ArbOwnerIf/ArbOwnerMem
  - reuse of RstEnable (redefined 1'b0 for this block's reset sense), ChipEnable, WriteEnable, ZeroWord
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Load with zero wait:
  - Stimulus: dm_ce_i=1, we=0, addr=0x100, sel=4'b1111, ack in cycle 1 with 0xDEADBEEF.
  - Response: bus_addr_o=0x100 in cycle 1; dm_data_o=0xDEADBEEF and stallreq_mem_o=0 in cycle 2 only.
- Simultaneous requests:
  - Stimulus: if_ce_i and dm_ce_i both high (store 0x11223344 to 0x200, sel 4'b0010).
  - Response: store granted first with bus_we_o=1, bus_sel_o=4'b0010; IF granted after MEM DONE; stallreq_if_o high until IF DONE.
- Wait states:
  - Stimulus: ack delayed 3 cycles on fetch of 0x0.
  - Response: bus_* stable 4 cycles, if_data_o valid in cycle 5.
- Flush in BUSY:
  - Stimulus: flush_i pulsed in BUSY.
  - Response: bus held until ack, no DONE cycle, if_data_o stays 0, next request granted the cycle after return to IDLE.
- Async reset mid-access:
  - Stimulus: rst=0 between clock edges in BUSY.
  - Response: bus_ce_o=0 immediately; after release, state IDLE and a new access completes normally.
- With MEM_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - Response: bus_err_o pulses 1 cycle after the 4th BUSY cycle, dm_data_o=0 in DONE, stall released.
